// File: rtl/path_stack.sv
// LIFO path stack with an in-order replay mode: entries are pushed/popped as a
// stack, and a replay pass streams them bottom-to-top without disturbing them.
module path_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             replay_start,
    input  logic             replay_next,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] poped,
    output logic             poped_valid,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic [AW-1:0]    count,
    output logic             is_empty,
    output logic             is_full,
    output logic             busy,
    output logic             all_read,
    output logic             overflow,
    output logic             underflow,
    output logic             blocked
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic {IDLE, REPLAY} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    count_reg, count_next;
    logic [AW-1:0]    cursor_reg, cursor_next;
    logic [WIDTH-1:0] poped_reg, poped_next;
    logic [WIDTH-1:0] pout_reg, pout_next;
    logic             poped_valid_reg, poped_valid_next;
    logic             pout_valid_reg, pout_valid_next;
    logic             overflow_reg, underflow_reg, blocked_reg;
    logic             ovf_evt, udf_evt, blk_evt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             we;
    logic [IW-1:0]    waddr;
    logic [IW-1:0]    top_idx, cur_idx;

    assign top_idx = IW'(count_reg - ONE);
    assign cur_idx = IW'(cursor_reg);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        cursor_next      = cursor_reg;
        poped_next       = poped_reg;
        pout_next        = pout_reg;
        poped_valid_next = 1'b0;
        pout_valid_next  = 1'b0;
        we               = 1'b0;
        waddr            = top_idx;
        ovf_evt          = 1'b0;
        udf_evt          = 1'b0;
        blk_evt          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (replay_start) begin
                    state_next  = REPLAY;
                    cursor_next = '0;
                end else if (push && pop && count_reg != '0) begin
                    // Swap the top: old value out, new value in, occupancy unchanged.
                    poped_next       = mem[top_idx];
                    poped_valid_next = 1'b1;
                    we               = 1'b1;
                end else if (push) begin
                    udf_evt = pop;
                    if (count_reg == FULL_CNT) begin
                        ovf_evt = 1'b1;
                    end else begin
                        we         = 1'b1;
                        waddr      = IW'(count_reg);
                        count_next = count_reg + ONE;
                    end
                end else if (pop) begin
                    if (count_reg == '0) begin
                        udf_evt = 1'b1;
                    end else begin
                        poped_next       = mem[top_idx];
                        poped_valid_next = 1'b1;
                        count_next       = count_reg - ONE;
                    end
                end
            end
            REPLAY: begin
                blk_evt = push | pop;
                if (replay_start) begin
                    cursor_next = '0;
                end else if (cursor_reg == count_reg) begin
                    // Everything emitted: all_read was visible for one cycle, leave now.
                    state_next = IDLE;
                end else if (replay_next) begin
                    pout_next       = mem[cur_idx];
                    pout_valid_next = 1'b1;
                    cursor_next     = cursor_reg + ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            cursor_reg      <= '0;
            poped_reg       <= '0;
            pout_reg        <= '0;
            poped_valid_reg <= 1'b0;
            pout_valid_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
            blocked_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            cursor_reg      <= cursor_next;
            poped_reg       <= poped_next;
            pout_reg        <= pout_next;
            poped_valid_reg <= poped_valid_next;
            pout_valid_reg  <= pout_valid_next;
            // A same-cycle error event beats clr_err.
            overflow_reg    <= ovf_evt | (overflow_reg & ~clr_err);
            underflow_reg   <= udf_evt | (underflow_reg & ~clr_err);
            blocked_reg     <= blk_evt | (blocked_reg & ~clr_err);
        end
    end

    assign top         = (count_reg == '0) ? '0 : mem[top_idx];
    assign poped       = poped_reg;
    assign poped_valid = poped_valid_reg;
    assign pout        = pout_reg;
    assign pout_valid  = pout_valid_reg;
    assign count       = count_reg;
    assign is_empty    = (count_reg == '0);
    assign is_full     = (count_reg == FULL_CNT);
    assign busy        = (state_reg == REPLAY);
    assign all_read    = (state_reg == REPLAY) && (cursor_reg == count_reg);
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign blocked     = blocked_reg;
endmodule

// File: tb/tb_path_stack.sv
// Bench for path_stack: directed scenarios plus randomized traffic compared
// against a queue-based model of the stack and its replay pass.
module tb_path_stack;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0, pop = 1'b0;
    logic             replay_start = 1'b0, replay_next = 1'b0, clr_err = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] top, poped, pout;
    logic             poped_valid, pout_valid;
    logic [AW-1:0]    count;
    logic             is_empty, is_full, busy, all_read;
    logic             overflow, underflow, blocked;

    int vectors = 0;
    int errors  = 0;

    path_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .replay_start(replay_start), .replay_next(replay_next), .clr_err(clr_err),
        .top(top), .poped(poped), .poped_valid(poped_valid),
        .pout(pout), .pout_valid(pout_valid), .count(count),
        .is_empty(is_empty), .is_full(is_full), .busy(busy), .all_read(all_read),
        .overflow(overflow), .underflow(underflow), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue, the bottom entry is index 0.
    logic [WIDTH-1:0] m_stack[$];
    bit               m_replay;
    int               m_cursor;
    bit               m_ovf, m_udf, m_blk, m_pv, m_ov;
    logic [WIDTH-1:0] m_poped, m_pout;

    task automatic model_reset();
        m_stack.delete();
        m_replay = 0; m_cursor = 0;
        m_ovf = 0; m_udf = 0; m_blk = 0; m_pv = 0; m_ov = 0;
        m_poped = '0; m_pout = '0;
    endtask

    task automatic model_step(bit ps, bit pp, logic [WIDTH-1:0] d, bit rs, bit rn, bit ce);
        bit e_o = 0, e_u = 0, e_b = 0;
        m_pv = 0; m_ov = 0;
        if (!m_replay) begin
            if (rs) begin
                m_replay = 1; m_cursor = 0;
            end else begin
                if (pp) begin
                    if (m_stack.size() == 0) e_u = 1;
                    else begin m_poped = m_stack.pop_back(); m_pv = 1; end
                end
                if (ps) begin
                    if (m_stack.size() >= DEPTH) e_o = 1;
                    else m_stack.push_back(d);
                end
            end
        end else begin
            e_b = ps | pp;
            if (rs) m_cursor = 0;
            else if (m_cursor == m_stack.size()) m_replay = 0;
            else if (rn) begin
                m_pout = m_stack[m_cursor]; m_ov = 1; m_cursor++;
            end
        end
        m_ovf = e_o | (m_ovf & !ce);
        m_udf = e_u | (m_udf & !ce);
        m_blk = e_b | (m_blk & !ce);
    endtask

    // One clock with the given inputs; outputs are stable 1 time unit after the edge.
    task automatic apply(bit ps, bit pp, logic [WIDTH-1:0] d, bit rs, bit rn, bit ce);
        push = ps; pop = pp; din = d; replay_start = rs; replay_next = rn; clr_err = ce;
        @(posedge clk);
        model_step(ps, pp, d, rs, rn, ce);
        #1;
        push = 0; pop = 0; replay_start = 0; replay_next = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        vectors++;
        if ({count, busy, poped_valid, pout_valid, top, overflow, underflow, blocked, is_empty}
            !== {AW'(0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got count=%0d busy=%b pv=%b ov=%b top=%0d err=%b%b%b empty=%b",
                     count, busy, poped_valid, pout_valid, top, overflow, underflow, blocked, is_empty);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        $display("reset: count=%0d busy=%b is_empty=%b", count, busy, is_empty);
    endtask

    task automatic test_push_pop();
        apply(1, 0, 2'd1, 0, 0, 0);
        apply(1, 0, 2'd2, 0, 0, 0);
        apply(1, 0, 2'd3, 0, 0, 0);
        vectors++;
        if (count !== AW'(3) || top !== 2'd3) begin
            errors++;
            $display("FAIL push3: got count=%0d top=%0d, need count=3 top=3", count, top);
        end
        apply(0, 1, 2'd0, 0, 0, 0);
        vectors++;
        if (poped !== 2'd3 || poped_valid !== 1'b1 || count !== AW'(2)) begin
            errors++;
            $display("FAIL pop: got poped=%0d pv=%b count=%0d, need 3 1 2", poped, poped_valid, count);
        end
        apply(0, 0, 2'd0, 0, 0, 0);
        vectors++;
        if (poped_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_pulse: poped_valid=%b one cycle later, need 0", poped_valid);
        end
        $display("push_pop: count=%0d top=%0d poped=%0d", count, top, poped);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) apply(1, 0, 2'(i), 0, 0, 0);
        vectors++;
        if (count !== AW'(4) || is_full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got count=%0d full=%b ovf=%b, need 4 1 1", count, is_full, overflow);
        end
        apply(1, 0, 2'd2, 0, 0, 1);
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_beats_clr: overflow=%b, need 1", overflow);
        end
        apply(0, 0, 2'd0, 0, 0, 1);
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: overflow=%b, need 0", overflow);
        end
        for (int i = 3; i >= 0; i--) begin
            apply(0, 1, 2'd0, 0, 0, 0);
            vectors++;
            if (poped !== 2'(i) || poped_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_contents[%0d]: got %0d pv=%b, need %0d", i, poped, poped_valid, i);
            end
        end
        $display("overflow: count=%0d overflow=%b", count, overflow);
    endtask

    task automatic test_underflow();
        do_reset();
        apply(0, 1, 2'd0, 0, 0, 0);
        vectors++;
        if (underflow !== 1'b1 || poped_valid !== 1'b0 || poped !== 2'd0) begin
            errors++;
            $display("FAIL underflow: got udf=%b pv=%b poped=%0d, need 1 0 0", underflow, poped_valid, poped);
        end
        apply(1, 0, 2'd2, 0, 0, 0);
        apply(1, 0, 2'd1, 0, 0, 0);
        apply(1, 1, 2'd3, 0, 0, 0);
        vectors++;
        if (poped !== 2'd1 || poped_valid !== 1'b1 || top !== 2'd3 || count !== AW'(2)) begin
            errors++;
            $display("FAIL push_pop_same: got poped=%0d pv=%b top=%0d count=%0d, need 1 1 3 2",
                     poped, poped_valid, top, count);
        end
        $display("underflow: underflow=%b top=%0d count=%0d", underflow, top, count);
    endtask

    task automatic test_replay();
        do_reset();
        for (int i = 0; i < 3; i++) apply(1, 0, 2'(i), 0, 0, 0);
        apply(0, 0, 2'd0, 1, 0, 0);
        vectors++;
        if (busy !== 1'b1 || all_read !== 1'b0) begin
            errors++;
            $display("FAIL replay_enter: busy=%b all_read=%b, need 1 0", busy, all_read);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 2'd0, 0, 1, 0);
            vectors++;
            if (pout !== 2'(i) || pout_valid !== 1'b1) begin
                errors++;
                $display("FAIL replay_out[%0d]: got pout=%0d pv=%b, need %0d 1", i, pout, pout_valid, i);
            end
        end
        vectors++;
        if (all_read !== 1'b1) begin
            errors++;
            $display("FAIL all_read: got %b, need 1", all_read);
        end
        apply(1, 0, 2'd3, 0, 0, 0);
        vectors++;
        if (blocked !== 1'b1 || count !== AW'(3) || busy !== 1'b0) begin
            errors++;
            $display("FAIL blocked: got blocked=%b count=%0d busy=%b, need 1 3 0", blocked, count, busy);
        end
        $display("replay: pout=%0d blocked=%b busy=%b", pout, blocked, busy);
    endtask

    task automatic test_reset_mid_replay();
        apply(0, 0, 2'd0, 1, 0, 0);
        apply(0, 0, 2'd0, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (count !== AW'(0) || busy !== 1'b0 || pout_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d busy=%b pv=%b, need 0 0 0", count, busy, pout_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        $display("reset_mid_replay: count=%0d busy=%b", count, busy);
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        int          bad = 0;
        for (int n = 0; n < 400; n++) begin
            bit ps = ($urandom_range(0, 99) < 45);
            bit pp = ($urandom_range(0, 99) < 35);
            bit rs = ($urandom_range(0, 99) < 6);
            bit rn = ($urandom_range(0, 99) < 60);
            bit ce = ($urandom_range(0, 99) < 10);
            apply(ps, pp, 2'($urandom), rs, rn, ce);
            got = 32'({top, poped, poped_valid, pout, pout_valid, count,
                       is_empty, is_full, busy, all_read, overflow, underflow, blocked});
            exp = 32'({(m_stack.size() == 0) ? 2'd0 : m_stack[m_stack.size() - 1],
                       m_poped, m_pv, m_pout, m_ov, AW'(m_stack.size()),
                       m_stack.size() == 0, m_stack.size() == DEPTH, m_replay,
                       m_replay && (m_cursor == m_stack.size()), m_ovf, m_udf, m_blk});
            vectors++;
            if (got !== exp) begin
                errors++;
                bad++;
                $display("FAIL random[%0d]: got %h need %h", n, got, exp);
            end
        end
        $display("random: 400 cycles, %0d miscompared", bad);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replay();
        test_reset_mid_replay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
